token_sampler: RTL and testbench
================================

Name: token_sampler

Overview:
- Downstream stage of the inference FSM; consumes the VOCAB_SIZE logits it produces as a valid/ready stream, one per handshake.
- Selects the next output token, either greedy argmax or LFSR-driven top-2 sampling gated by a margin.
- Presents the token with a valid/ready handshake and holds it, so it feeds back into the inference FSM's token input for the next step.

Parameters:
- VOCAB_SIZE, 76, logits per frame; must be at least 2.
- DATA_WIDTH, 16, logit width; signed two's complement Q8.8.
- TOKEN_WIDTH, 7, width of the token index.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- greedy  in  1  1 = argmax, 0 = top-2 sampling; sampled in DECIDE.
- margin  in  DATA_WIDTH  unsigned top-2 threshold (Q8.8); sampled in DECIDE.
- logit_valid  in  1  logit_data is valid.
- logit_ready  out  1  sampler accepts a logit this cycle.
- logit_data  in  DATA_WIDTH  signed logit.
- logit_last  in  1  marks the final logit of a frame.
- token_valid  out  1  output_token is valid.
- token_ready  in  1  consumer accepts the token.
- output_token  out  TOKEN_WIDTH  selected token index, held until the next decision.
- max_logit  out  DATA_WIDTH  best logit value of the last frame.
- busy  out  1  high in any state other than IDLE.
- error  out  1  frame-length mismatch, sticky until the next accepted start.

Behaviour:
- Reset (asserted low, asynchronous): state = IDLE; all outputs 0; count = 0; best_val = second_val = 16'h8000; best_idx = second_idx = 0; second_seen = 0; LFSR = LFSR_SEED.
- States: IDLE, COLLECT, DECIDE, OUTPUT.
- IDLE:
  - logit_ready = 0, token_valid = 0.
  - On start: clear count, best/second registers, second_seen and error; go to COLLECT.
- COLLECT:
  - logit_ready = 1; a handshake is logit_valid & logit_ready.
  - On each handshake, with idx = count:
    - If logit_data > best_val (signed, strictly greater): second <= best; second_seen <= (count != 0); best <= (logit_data, idx).
    - Else if logit_data > second_val or !second_seen: second <= (logit_data, idx); second_seen <= 1.
    - Ties keep the lower index.
  - count increments on every handshake.
  - Leave for DECIDE on a handshake where logit_last = 1 or count == VOCAB_SIZE-1.
  - error <= 1 if logit_last arrives with count != VOCAB_SIZE-1, or count reaches VOCAB_SIZE-1 without logit_last.
  - A token is still produced from the logits received.
- DECIDE (exactly one cycle):
  - diff = best_val - second_val, computed at 17 bits (always >= 0).
  - Pick second_idx only if greedy = 0, second_seen = 1, diff <= margin and lfsr[0] = 1.
  - Otherwise pick best_idx.
  - Register output_token and max_logit <= best_val; go to OUTPUT.
- OUTPUT:
  - token_valid = 1; output_token is stable while waiting.
  - On token_ready: go to IDLE; output_token keeps its value.
- Latency: final logit handshake at cycle N, DECIDE at N+1, token_valid high at N+2.
- LFSR: 16-bit Fibonacci, taps 16, 14, 13, 11; advances every clock in every state.
- start outside IDLE is ignored.
- logit_valid outside COLLECT is ignored (not accepted).
- Reset asserted mid-frame aborts the frame and restores the reset values above.

Decomposition:
- Package inference_pkg holds:
  - VOCAB_SIZE, EMBEDDING_SIZE, LINEAR_SIZE.
  - Q8.8 constant LOGIT_MIN = 16'h8000.
  - sampler_state_t enum.
- One sub-module: lfsr16, parameterised by seed, with an enable input tied high.

Test Plan:
- Greedy: 76 logits, all 16'hFF00 except index 42 = 16'h0300, last on index 75 -> output_token = 42, max_logit = 16'h0300, token_valid at N+2, error = 0.
- Tie: indices 5 and 60 both 16'h0100, rest negative, greedy = 1 -> output_token = 5.
- Top-2: best 16'h0200 at index 10, second 16'h01F0 at index 20, margin 16'h0020, greedy = 0, over 64 frames -> both 10 and 20 occur. With margin 16'h0008 -> always 10.
- Early last: logit_last on the 30th logit (count = 29) -> error = 1, token is the argmax of the 30 logits, error clears on the next start.
- Backpressure: token_ready held low for 10 cycles -> token_valid and output_token stable throughout, logit_ready = 0, and start is ignored.
- Reset mid-COLLECT after 20 logits -> all outputs 0 immediately; a following full frame behaves exactly like the greedy scenario.

Source files
------------

// File: rtl/inference_pkg.sv
// Shared constants and types for the inference pipeline and its token sampler.
package inference_pkg;

   localparam int VOCAB_SIZE     = 76;
   localparam int EMBEDDING_SIZE = 32;
   localparam int LINEAR_SIZE    = 64;

   // Most negative Q8.8 value; seeds the running best/second trackers.
   localparam logic [15:0] LOGIT_MIN = 16'h8000;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      DECIDE,
      OUTPUT
   } sampler_state_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11) used as the sampler's coin source.
module lfsr16 #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   output logic [15:0] value
);

   logic feedback;

   assign feedback = value[15] ^ value[13] ^ value[12] ^ value[10];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         value <= SEED;
      end else if (enable) begin
         value <= {value[14:0], feedback};
      end
   end

endmodule

// File: rtl/token_sampler.sv
// Picks the next token from a streamed logit frame: greedy argmax, or a
// margin-gated coin flip between the two best candidates.
module token_sampler #(
   parameter int          VOCAB_SIZE  = 76,
   parameter int          DATA_WIDTH  = 16,
   parameter int          TOKEN_WIDTH = 7,
   parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          greedy,
   input  logic [DATA_WIDTH-1:0]         margin,
   input  logic                          logit_valid,
   output logic                          logit_ready,
   input  logic signed [DATA_WIDTH-1:0]  logit_data,
   input  logic                          logit_last,
   output logic                          token_valid,
   input  logic                          token_ready,
   output logic [TOKEN_WIDTH-1:0]        output_token,
   output logic [DATA_WIDTH-1:0]         max_logit,
   output logic                          busy,
   output logic                          error
);

   import inference_pkg::*;

   localparam logic [TOKEN_WIDTH-1:0] LAST_IDX = TOKEN_WIDTH'(VOCAB_SIZE - 1);
   localparam logic signed [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   sampler_state_t state, next_state;

   logic [TOKEN_WIDTH-1:0]        count;
   logic [TOKEN_WIDTH-1:0]        best_idx, second_idx;
   logic signed [DATA_WIDTH-1:0]  best_val, second_val;
   logic                          second_seen;
   logic [15:0]                   lfsr_value;
   logic                          in_collect;
   logic                          handshake;
   logic                          frame_end;
   logic [DATA_WIDTH:0]           diff;
   logic                          pick_second;

   lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk    (clk),
      .reset  (reset),
      .enable (1'b1),
      .value  (lfsr_value)
   );

   assign in_collect  = (state == COLLECT);
   assign logit_ready = in_collect;
   assign handshake   = logit_valid & in_collect;
   assign frame_end   = handshake & (logit_last | (count == LAST_IDX));

   // Sign-extend before subtracting so the full Q8.8 range cannot overflow.
   assign diff        = {best_val[DATA_WIDTH-1], best_val} - {second_val[DATA_WIDTH-1], second_val};
   assign pick_second = !greedy && second_seen && (diff <= {1'b0, margin}) && lfsr_value[0];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state  = state;
      token_valid = 1'b0;
      busy        = (state != IDLE);
      unique case (state)
         IDLE:    if (start) next_state = COLLECT;
         COLLECT: if (frame_end) next_state = DECIDE;
         DECIDE:  next_state = OUTPUT;
         OUTPUT: begin
            token_valid = 1'b1;
            if (token_ready) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Running top-2 tracker; ties keep the earlier index because only a
   // strictly greater logit displaces a held candidate.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count        <= '0;
         best_val     <= MIN_VAL;
         second_val   <= MIN_VAL;
         best_idx     <= '0;
         second_idx   <= '0;
         second_seen  <= 1'b0;
         error        <= 1'b0;
         output_token <= '0;
         max_logit    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  count       <= '0;
                  best_val    <= MIN_VAL;
                  second_val  <= MIN_VAL;
                  best_idx    <= '0;
                  second_idx  <= '0;
                  second_seen <= 1'b0;
                  error       <= 1'b0;
               end
            end
            COLLECT: begin
               if (handshake) begin
                  count <= count + 1'b1;
                  if (logit_data > best_val) begin
                     second_val  <= best_val;
                     second_idx  <= best_idx;
                     second_seen <= (count != '0);
                     best_val    <= logit_data;
                     best_idx    <= count;
                  end else if ((logit_data > second_val) || !second_seen) begin
                     second_val  <= logit_data;
                     second_idx  <= count;
                     second_seen <= 1'b1;
                  end
                  if (logit_last != (count == LAST_IDX)) error <= 1'b1;
               end
            end
            DECIDE: begin
               output_token <= pick_second ? second_idx : best_idx;
               max_logit    <= best_val;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_token_sampler.sv
// Directed frame-level bench for token_sampler: table of frames plus
// hand-written backpressure, sampling and mid-frame reset sequences.
module tb_token_sampler;

   import inference_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        greedy = 1'b1;
   logic [15:0] margin = '0;
   logic        logit_valid = 1'b0;
   logic        logit_ready;
   logic [15:0] logit_data = '0;
   logic        logit_last = 1'b0;
   logic        token_valid;
   logic        token_ready = 1'b0;
   logic [6:0]  output_token;
   logic [15:0] max_logit;
   logic        busy;
   logic        error;

   int total = 0;
   int bad   = 0;

   typedef struct {
      string       name;
      logic        greedy;
      logic [15:0] margin;
      logic [15:0] fill;
      int          idxA;
      logic [15:0] valA;
      int          idxB;
      logic [15:0] valB;
      int          lastCount;
      logic        sendLast;
      int          expToken;
      logic [15:0] expMax;
      logic        expErr;
   } vec_t;

   vec_t vecs[9];

   token_sampler #(
      .VOCAB_SIZE  (76),
      .DATA_WIDTH  (16),
      .TOKEN_WIDTH (7),
      .LFSR_SEED   (16'hACE1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .greedy       (greedy),
      .margin       (margin),
      .logit_valid  (logit_valid),
      .logit_ready  (logit_ready),
      .logit_data   (logit_data),
      .logit_last   (logit_last),
      .token_valid  (token_valid),
      .token_ready  (token_ready),
      .output_token (output_token),
      .max_logit    (max_logit),
      .busy         (busy),
      .error        (error)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] logitAt(input vec_t v, input int i);
      logic [15:0] d;
      d = v.fill;
      if (i == v.idxA) d = v.valA;
      if (i == v.idxB) d = v.valB;
      return d;
   endfunction

   // Runs one frame; holdCycles > 0 keeps token_ready low while poking start/logit_valid.
   task automatic applyStimulus(input vec_t v, input int holdCycles,
                                output int tok, output logic [15:0] mx, output logic er);
      int guard;
      greedy = v.greedy;
      margin = v.margin;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("busy after start", busy, 1);
      checkOutput("error cleared by start", error, 0);
      for (int i = 0; i <= v.lastCount; i++) begin
         logit_valid = 1'b1;
         logit_data  = logitAt(v, i);
         logit_last  = v.sendLast && (i == v.lastCount);
         guard = 0;
         while (!logit_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
         end
         if (guard == 20) checkOutput("logit_ready wait", logit_ready, 1);
         @(posedge clk); #1;
      end
      logit_valid = 1'b0;
      logit_last  = 1'b0;
      checkOutput("token_valid low at N+1", token_valid, 0);
      @(posedge clk); #1;
      checkOutput("token_valid high at N+2", token_valid, 1);
      tok = int'(output_token);
      mx  = max_logit;
      er  = error;
      for (int c = 0; c < holdCycles; c++) begin
         start       = (c == 3);
         logit_valid = (c == 5);
         @(posedge clk); #1;
         checkOutput("hold token_valid", token_valid, 1);
         checkOutput("hold output_token", output_token, tok);
         checkOutput("hold logit_ready", logit_ready, 0);
      end
      start       = 1'b0;
      logit_valid = 1'b0;
      token_ready = 1'b1;
      @(posedge clk); #1;
      token_ready = 1'b0;
      checkOutput("idle after accept", busy, 0);
      checkOutput("token kept after accept", output_token, tok);
   endtask

   initial begin
      int          tok;
      logic [15:0] mx;
      logic        er;
      int          seen10, seen20, seenOther;
      vec_t        topVec;

      vecs[0] = '{"greedy",     1'b1, 16'h0000, 16'hFF00, 42, 16'h0300, 42, 16'h0300, 75, 1'b1, 42, 16'h0300, 1'b0};
      vecs[1] = '{"tie",        1'b1, 16'h0000, 16'hFF00,  5, 16'h0100, 60, 16'h0100, 75, 1'b1,  5, 16'h0100, 1'b0};
      vecs[2] = '{"early last", 1'b1, 16'h0000, 16'hFF80, 12, 16'h0050, 40, 16'h0700, 29, 1'b1, 12, 16'h0050, 1'b1};
      vecs[3] = '{"all equal",  1'b1, 16'h0000, 16'h0010,  0, 16'h0010,  0, 16'h0010, 75, 1'b1,  0, 16'h0010, 1'b0};
      vecs[4] = '{"best last",  1'b1, 16'h0000, LOGIT_MIN, 75, 16'h7FFF, 75, 16'h7FFF, 75, 1'b1, 75, 16'h7FFF, 1'b0};
      vecs[5] = '{"all min",    1'b1, 16'h0000, LOGIT_MIN,  0, LOGIT_MIN, 0, LOGIT_MIN, 75, 1'b1,  0, 16'h8000, 1'b0};
      vecs[6] = '{"zero margin",1'b0, 16'h0000, 16'hFF00,  3, 16'h0100,  4, 16'h00FF, 75, 1'b1,  3, 16'h0100, 1'b0};
      vecs[7] = '{"neg best",   1'b1, 16'h0000, 16'hF000, 33, 16'hFFFF, 34, 16'hFFFE, 75, 1'b1, 33, 16'hFFFF, 1'b0};
      vecs[8] = '{"no last",    1'b1, 16'h0000, 16'h0001, 70, 16'h0002, 70, 16'h0002, 75, 1'b0, 70, 16'h0002, 1'b1};

      #12;
      checkOutput("reset token_valid", token_valid, 0);
      checkOutput("reset logit_ready", logit_ready, 0);
      checkOutput("reset output_token", output_token, 0);
      checkOutput("reset max_logit", max_logit, 0);
      checkOutput("reset busy", busy, 0);
      checkOutput("reset error", error, 0);
      @(negedge clk);
      reset = 1'b1;

      for (int k = 0; k < 9; k++) begin
         applyStimulus(vecs[k], 0, tok, mx, er);
         checkOutput({vecs[k].name, " token"}, tok, vecs[k].expToken);
         checkOutput({vecs[k].name, " max_logit"}, mx, vecs[k].expMax);
         checkOutput({vecs[k].name, " error"}, er, vecs[k].expErr);
      end

      applyStimulus(vecs[0], 10, tok, mx, er);
      checkOutput("backpressure token", tok, 42);

      topVec = '{"top2", 1'b0, 16'h0020, 16'hFF00, 10, 16'h0200, 20, 16'h01F0, 75, 1'b1, 10, 16'h0200, 1'b0};
      seen10 = 0; seen20 = 0; seenOther = 0;
      for (int f = 0; f < 64; f++) begin
         applyStimulus(topVec, 0, tok, mx, er);
         if (tok == 10) seen10++;
         else if (tok == 20) seen20++;
         else seenOther++;
      end
      checkOutput("top2 saw index 10", seen10 > 0, 1);
      checkOutput("top2 saw index 20", seen20 > 0, 1);
      checkOutput("top2 other indices", seenOther, 0);

      topVec.margin = 16'h0008;
      seenOther = 0;
      for (int f = 0; f < 16; f++) begin
         applyStimulus(topVec, 0, tok, mx, er);
         if (tok != 10) seenOther++;
      end
      checkOutput("narrow margin non-best picks", seenOther, 0);

      applyStimulus(vecs[8], 0, tok, mx, er);
      @(negedge clk);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         logit_valid = 1'b1;
         logit_data  = logitAt(vecs[0], i);
         @(posedge clk); #1;
      end
      logit_valid = 1'b0;
      #1;
      reset = 1'b0;
      #1;
      checkOutput("midreset output_token", output_token, 0);
      checkOutput("midreset max_logit", max_logit, 0);
      checkOutput("midreset busy", busy, 0);
      checkOutput("midreset logit_ready", logit_ready, 0);
      checkOutput("midreset token_valid", token_valid, 0);
      @(negedge clk);
      reset = 1'b1;
      applyStimulus(vecs[0], 0, tok, mx, er);
      checkOutput("post-reset token", tok, 42);
      checkOutput("post-reset max_logit", mx, 16'h0300);
      checkOutput("post-reset error", er, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
